// File: rtl/stage_sequencer.sv
// -----------------------------------------------------------------------------
// stage_sequencer
//
// Purpose:
//   Orders N_STAGES processing sub-blocks with a start/done handshake. On an
//   accepted `start` it pulses start_out for the first stage and waits for that
//   stage's done_in bit. Each completion then launches the next stage. The last
//   completion pulses `done`. A per-stage watchdog pulses `error` and records
//   the stalled stage in err_stage. `abort` cancels a run silently.
//
// Parameters:
//   N_STAGES  number of sequenced stages (2..16)
//   IDX_W     width of the stage index (2**IDX_W >= N_STAGES)
//   TO_W      width of the watchdog counter
//   TIMEOUT   maximum wait cycles per stage; 0 disables the watchdog
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      request a run; only looked at while idle
//   abort      cancel the running sequence
//   done_in    per-stage completion; only the awaited stage's bit matters
//   skip_mask  (STAGE_SKIP_EN only) stages to bypass, latched when start is accepted
//   start_out  one-cycle start pulse per stage, at most one bit high
//   busy       high while a stage is being awaited
//   stage_idx  index of the awaited stage, 0 when idle
//   done       one-cycle pulse when every (unskipped) stage has completed
//   error      one-cycle pulse when the awaited stage timed out
//   err_stage  stage that last timed out, held until the next error or reset
//
// Configuration macro:
//   STAGE_SKIP_EN  adds the skip_mask input and stage bypassing
// -----------------------------------------------------------------------------
module stage_sequencer #(
  parameter int N_STAGES = 3,
  parameter int IDX_W    = 2,
  parameter int TO_W     = 16,
  parameter int TIMEOUT  = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [N_STAGES-1:0] done_in,
`ifdef STAGE_SKIP_EN
  input  logic [N_STAGES-1:0] skip_mask,
`endif
  output logic [N_STAGES-1:0] start_out,
  output logic                busy,
  output logic [IDX_W-1:0]    stage_idx,
  output logic                done,
  output logic                error,
  output logic [IDX_W-1:0]    err_stage
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [TO_W-1:0] TO_VAL  = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0] CNT_MAX = '1;

  state_t                state_q, state_d;
  logic [TO_W-1:0]       cnt_q, cnt_d;
  logic [N_STAGES-1:0]   start_out_d;
  logic                  busy_d, done_d, error_d;
  logic [IDX_W-1:0]      stage_idx_d, err_stage_d;
  logic [IDX_W:0]        nxt;
  logic [N_STAGES-1:0]   start_mask;
  logic [N_STAGES-1:0]   run_mask;

  // Finds the lowest stage at or above `lo` that is not masked out. The top
  // bit of the result says whether such a stage exists at all; when it does
  // not, the sequence is complete.
  function automatic logic [IDX_W:0] next_stage(input logic [N_STAGES-1:0] mask,
                                                input int lo);
    logic [IDX_W:0] res;
    res = '0;
    for (int i = N_STAGES - 1; i >= 0; i--) begin
      if (i >= lo && !mask[i]) res = {1'b1, IDX_W'(i)};
    end
    return res;
  endfunction

`ifdef STAGE_SKIP_EN
  logic [N_STAGES-1:0] skip_q, skip_d;

  // The mask is frozen for the whole run so a sub-block toggling skip_mask
  // mid-sequence cannot change which stages are launched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) skip_q <= '0;
    else     skip_q <= skip_d;
  end

  assign start_mask = skip_mask;
  assign run_mask   = skip_q;
`else
  assign start_mask = '0;
  assign run_mask   = '0;
`endif

  // State and every output live in registers so downstream blocks never see
  // combinational glitches from done_in. Reset drops everything, including the
  // held err_stage, without producing any pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      start_out <= '0;
      busy      <= 1'b0;
      stage_idx <= '0;
      done      <= 1'b0;
      error     <= 1'b0;
      err_stage <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      start_out <= start_out_d;
      busy      <= busy_d;
      stage_idx <= stage_idx_d;
      done      <= done_d;
      error     <= error_d;
      err_stage <= err_stage_d;
    end
  end

  // Next-state and next-output logic. In WAIT the events are checked in a
  // fixed priority: abort, then the awaited stage's done, then the watchdog.
  // That ordering lets a stage finishing on its very last allowed cycle still
  // count as a success. The counter reads 1 in the cycle start_out is high and
  // saturates instead of wrapping, so it stays well behaved even when the
  // watchdog is disabled and a stage waits forever.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    start_out_d = '0;
    busy_d      = busy;
    stage_idx_d = stage_idx;
    done_d      = 1'b0;
    error_d     = 1'b0;
    err_stage_d = err_stage;
    nxt         = '0;
`ifdef STAGE_SKIP_EN
    skip_d      = skip_q;
`endif
    case (state_q)
      IDLE: begin
        busy_d      = 1'b0;
        stage_idx_d = '0;
        cnt_d       = '0;
        if (start && !abort) begin
`ifdef STAGE_SKIP_EN
          skip_d = skip_mask;
`endif
          nxt = next_stage(start_mask, 0);
          if (nxt[IDX_W]) begin
            state_d                    = WAIT;
            start_out_d[nxt[IDX_W-1:0]] = 1'b1;
            busy_d                     = 1'b1;
            stage_idx_d                = nxt[IDX_W-1:0];
            cnt_d                      = TO_W'(1);
          end else begin
            done_d = 1'b1;
          end
        end
      end
      WAIT: begin
        if (abort) begin
          state_d     = IDLE;
          busy_d      = 1'b0;
          stage_idx_d = '0;
          cnt_d       = '0;
        end else if (done_in[stage_idx]) begin
          nxt = next_stage(run_mask, int'(stage_idx) + 1);
          if (nxt[IDX_W]) begin
            start_out_d[nxt[IDX_W-1:0]] = 1'b1;
            stage_idx_d                = nxt[IDX_W-1:0];
            cnt_d                      = TO_W'(1);
          end else begin
            state_d     = IDLE;
            done_d      = 1'b1;
            busy_d      = 1'b0;
            stage_idx_d = '0;
            cnt_d       = '0;
          end
        end else if (TIMEOUT != 0 && cnt_q == TO_VAL) begin
          state_d     = IDLE;
          error_d     = 1'b1;
          err_stage_d = stage_idx;
          busy_d      = 1'b0;
          stage_idx_d = '0;
          cnt_d       = '0;
        end else begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + TO_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_stage_sequencer.sv
// -----------------------------------------------------------------------------
// tb_stage_sequencer
//
// Scoreboard bench for stage_sequencer with N_STAGES=3 and TIMEOUT=4. The
// driver applies inputs on the falling edge and asks a stage-level reference
// model what the outputs must look like after the next rising edge. That
// expectation is queued. A monitor pops and compares one entry per rising
// edge. Directed runs cover the test-plan scenarios; a random run follows.
// -----------------------------------------------------------------------------
module tb_stage_sequencer;

  localparam int N  = 3;
  localparam int IW = 2;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [N-1:0]  done_in;
  logic [N-1:0]  start_out;
  logic          busy;
  logic [IW-1:0] stage_idx;
  logic          done;
  logic          error;
  logic [IW-1:0] err_stage;
`ifdef STAGE_SKIP_EN
  logic [N-1:0]  skip_mask;
`endif

  stage_sequencer #(
    .N_STAGES (N),
    .IDX_W    (IW),
    .TO_W     (16),
    .TIMEOUT  (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .done_in   (done_in),
`ifdef STAGE_SKIP_EN
    .skip_mask (skip_mask),
`endif
    .start_out (start_out),
    .busy      (busy),
    .stage_idx (stage_idx),
    .done      (done),
    .error     (error),
    .err_stage (err_stage)
  );

  // Free-running clock with a 10-unit period.
  always #5 clk = ~clk;

  int         n_compared   = 0;
  int         n_mismatched = 0;
  logic [9:0] exp_q[$];

  // Reference model state: the awaited stage (-1 when idle), how many cycles
  // it has been awaited, the stage of the last timeout, and the latched mask.
  int         cur      = -1;
  int         waited   = 0;
  int         last_err = 0;
  logic [N-1:0] mask_r = '0;

  // Packs the DUT outputs in the same order as the model's expectations.
  function automatic logic [9:0] pack_out();
    return {start_out, busy, stage_idx, done, error, err_stage};
  endfunction

  // Lowest stage at or above lo that is not skipped, or -1.
  function automatic int first_free(input logic [N-1:0] m, input int lo);
    for (int i = lo; i < N; i++) if (!m[i]) return i;
    return -1;
  endfunction

  // One clock of the sequencer's behaviour expressed in stage terms: what
  // happens to the awaited stage given this cycle's inputs, and which pulses
  // that produces.
  task model_step(input logic s, input logic a, input logic [N-1:0] d,
                  input logic [N-1:0] m, output logic [9:0] e);
    logic [N-1:0]  so;
    logic          dn;
    logic          er;
    logic [IW-1:0] idx;
    int            nx;
    so = '0;
    dn = 1'b0;
    er = 1'b0;
    if (cur < 0) begin
      if (s && !a) begin
        mask_r = m;
        nx = first_free(mask_r, 0);
        if (nx < 0) dn = 1'b1;
        else begin
          cur = nx;
          waited = 1;
          so[nx] = 1'b1;
        end
      end
    end else if (a) begin
      cur = -1;
    end else if (d[cur]) begin
      nx = first_free(mask_r, cur + 1);
      if (nx < 0) begin
        dn = 1'b1;
        cur = -1;
      end else begin
        cur = nx;
        waited = 1;
        so[nx] = 1'b1;
      end
    end else if (waited == TO) begin
      er = 1'b1;
      last_err = cur;
      cur = -1;
    end else begin
      waited++;
    end
    idx = (cur >= 0) ? IW'(cur) : '0;
    e = {so, cur >= 0, idx, dn, er, IW'(last_err)};
  endtask

  // Compares an output bundle against its expectation and reports any difference.
  task checkOutput(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s @%0t: actual start_out=%b busy=%b stage_idx=%0d done=%b error=%b err_stage=%0d, required start_out=%b busy=%b stage_idx=%0d done=%b error=%b err_stage=%0d",
               name, $time, act[9:7], act[6], act[5:4], act[3], act[2], act[1:0],
               exp[9:7], exp[6], exp[5:4], exp[3], exp[2], exp[1:0]);
    end
  endtask

  // Drives one cycle of inputs on the falling edge and queues the expected outputs.
  task applyStimulus(input logic s, input logic a, input logic [N-1:0] d,
                     input logic [N-1:0] m);
    logic [9:0] e;
    logic [N-1:0] meff;
    @(negedge clk);
    start   = s;
    abort   = a;
    done_in = d;
`ifdef STAGE_SKIP_EN
    skip_mask = m;
    meff = m;
`else
    meff = '0;
`endif
    model_step(s, a, d, meff, e);
    exp_q.push_back(e);
  endtask

  // Several idle cycles with nothing requested.
  task idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, '0);
  endtask

  // Asserts reset between clock edges and checks that the outputs clear
  // before any rising edge arrives.
  task resetMidCycle();
    @(negedge clk);
    #2;
    rst     = 1'b1;
    start   = 1'b0;
    abort   = 1'b0;
    done_in = '0;
    #1;
    checkOutput("async_reset", pack_out(), 10'b0);
    cur      = -1;
    waited   = 0;
    last_err = 0;
    mask_r   = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: one expectation is due after every rising edge that followed a
  // driven cycle.
  initial begin
    logic [9:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("cycle", pack_out(), e);
      end
    end
  end

  // Main stimulus: reset check, the directed scenarios, then a random run.
  initial begin
    int qsz;
    rst     = 1'b1;
    start   = 1'b0;
    abort   = 1'b0;
    done_in = '0;
`ifdef STAGE_SKIP_EN
    skip_mask = '0;
`endif
    #1;
    checkOutput("reset_state", pack_out(), 10'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    $display("[TB] reset released");

    // Normal run.
    applyStimulus(1'b1, 1'b0, 3'b000, '0);
    idleCycles(2);
    applyStimulus(1'b0, 1'b0, 3'b001, '0);
    applyStimulus(1'b0, 1'b0, 3'b000, '0);
    applyStimulus(1'b0, 1'b0, 3'b010, '0);
    applyStimulus(1'b0, 1'b0, 3'b100, '0);
    idleCycles(2);

    // Timeout on stage 0, then completion on the last allowed wait cycle.
    applyStimulus(1'b1, 1'b0, 3'b000, '0);
    idleCycles(6);
    applyStimulus(1'b1, 1'b0, 3'b000, '0);
    idleCycles(3);
    applyStimulus(1'b0, 1'b0, 3'b001, '0);
    idleCycles(6);

    // Abort together with done_in of stage 1; start and foreign done ignored.
    applyStimulus(1'b1, 1'b0, 3'b000, '0);
    applyStimulus(1'b1, 1'b0, 3'b100, '0);
    applyStimulus(1'b0, 1'b0, 3'b001, '0);
    applyStimulus(1'b0, 1'b1, 3'b010, '0);
    idleCycles(3);

    // Reset in the middle of stage 1, then a fresh run.
    applyStimulus(1'b1, 1'b0, 3'b000, '0);
    applyStimulus(1'b0, 1'b0, 3'b001, '0);
    applyStimulus(1'b0, 1'b0, 3'b000, '0);
    resetMidCycle();
    applyStimulus(1'b1, 1'b0, 3'b000, '0);
    applyStimulus(1'b0, 1'b0, 3'b111, '0);
    applyStimulus(1'b0, 1'b0, 3'b111, '0);
    applyStimulus(1'b0, 1'b0, 3'b111, '0);
    idleCycles(2);

    // Back-to-back runs with start held high.
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b0, 3'b111, '0);
    idleCycles(2);

`ifdef STAGE_SKIP_EN
    // Stage 1 skipped, then every stage skipped.
    applyStimulus(1'b1, 1'b0, 3'b000, 3'b010);
    applyStimulus(1'b0, 1'b0, 3'b001, 3'b000);
    applyStimulus(1'b0, 1'b0, 3'b100, 3'b000);
    idleCycles(2);
    applyStimulus(1'b1, 1'b0, 3'b000, 3'b111);
    idleCycles(2);
`endif

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      logic s, a;
      logic [N-1:0] d, m;
      s = ($urandom_range(3) == 0);
      a = ($urandom_range(19) == 0);
      for (int b = 0; b < N; b++) d[b] = ($urandom_range(2) == 0);
      m = ($urandom_range(3) == 0) ? N'($urandom_range(7)) : '0;
      applyStimulus(s, a, d, m);
    end
    idleCycles(1);

    @(negedge clk);
    @(negedge clk);
    qsz = exp_q.size();
    n_compared++;
    if (qsz != 0) begin
      n_mismatched++;
      $display("[TB] FAIL queue_drained: actual %0d entries left, required 0", qsz);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
